// File: rtl/dhcp_vlg_pkg.sv
// Shared definitions for the DHCP client control engine.
//   - DHCP option 53 message type codes used by the client
//   - client FSM state encoding
//   - IPv4 address type
//   - transaction-ID LFSR step function (32-bit Galois,
//     x^32 + x^22 + x^2 + x + 1)
package dhcp_vlg_pkg;

  // The address type is defined locally so that this slice builds on its own.
  typedef logic [31:0] ipv4_t;

  localparam logic [7:0] DHCP_MSG_DISCOVER = 8'd1;
  localparam logic [7:0] DHCP_MSG_OFFER    = 8'd2;
  localparam logic [7:0] DHCP_MSG_REQUEST  = 8'd3;
  localparam logic [7:0] DHCP_MSG_ACK      = 8'd5;
  localparam logic [7:0] DHCP_MSG_NAK      = 8'd6;

  typedef enum logic [2:0] {
    IDLE,
    DISC_S,
    OFFER_WAIT_S,
    REQ_S,
    ACK_WAIT_S,
    BOUND_S,
    FAIL_S
  } cli_state_e;

  // Right-shifting Galois form. The tap mask holds bit 31 (the x^32 term).
  // This makes the step a bijection, so a nonzero seed never reaches zero.
  localparam logic [31:0] XID_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? XID_POLY : 32'd0);
  endfunction

endpackage

// File: rtl/dhcp_vlg_xid_gen.sv
// Transaction-ID generator for the DHCP client.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset; reloads XID_SEED
//   adv  in   advance one LFSR step (asserted when a new xid is loaded)
//   xid  out  current transaction ID (the LFSR state)
module dhcp_vlg_xid_gen
  import dhcp_vlg_pkg::*;
#(
  parameter logic [31:0] XID_SEED = 32'hA5C3_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] xid
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= XID_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign xid = lfsr_q;

endmodule

// File: rtl/dhcp_vlg_cli_ctrl.sv
// DHCP client control engine: DISCOVER -> OFFER -> REQUEST -> ACK with
// timeouts and bounded retries. Decoded messages come from the RX parser.
// Frames are requested from the TX builder over a tx_req/tx_done handshake.
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   start                          begin acquisition (IDLE/BOUND_S/FAIL_S)
//   rx_v, rx_msg_type, rx_xid,     parsed message strobe and its fields
//   rx_yiaddr, rx_srv_id, rx_lease
//   tx_req, tx_msg_type, tx_xid,   transmit command, held until tx_done
//   tx_req_ipv4, tx_srv_id
//   tx_done                        builder accepted the frame
//   ipv4_addr, lease, ready        bound address/lease and bound flag
//   fail                           retries exhausted
// All outputs are registered.
module dhcp_vlg_cli_ctrl
  import dhcp_vlg_pkg::*;
#(
  parameter int          RETRIES  = 3,
  parameter int          TIMEOUT  = 1250000,
  parameter logic [31:0] XID_SEED = 32'hA5C3_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_v,
  input  logic [7:0]  rx_msg_type,
  input  logic [31:0] rx_xid,
  input  logic [31:0] rx_yiaddr,
  input  logic [31:0] rx_srv_id,
  input  logic [31:0] rx_lease,
  output logic        tx_req,
  output logic [7:0]  tx_msg_type,
  output logic [31:0] tx_xid,
  output logic [31:0] tx_req_ipv4,
  output logic [31:0] tx_srv_id,
  input  logic        tx_done,
  output logic [31:0] ipv4_addr,
  output logic [31:0] lease,
  output logic        ready,
  output logic        fail
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LAST = 4'(RETRIES - 1);

  cli_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  ipv4_t       offer_ip_q, offer_ip_d;
  ipv4_t       srv_q, srv_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  tx_msg_type_q, tx_msg_type_d;
  logic [31:0] tx_xid_q, tx_xid_d;
  ipv4_t       tx_req_ipv4_q, tx_req_ipv4_d;
  ipv4_t       tx_srv_id_q, tx_srv_id_d;
  ipv4_t       ipv4_addr_q, ipv4_addr_d;
  logic [31:0] lease_q, lease_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;

  logic        xid_adv;
  logic [31:0] xid;
  logic        rx_match;
  logic        timeout;
  logic        do_retry;
  logic        tx_ack;

  dhcp_vlg_xid_gen #(
    .XID_SEED(XID_SEED)
  ) u_xid_gen (
    .clk(clk),
    .rst(rst),
    .adv(xid_adv),
    .xid(xid)
  );

  assign rx_match = rx_v && (rx_xid == xid);
  assign timeout  = (timer_q == TIMER_LAST);
  // tx_done is only meaningful while a request is outstanding.
  assign tx_ack   = tx_req_q && tx_done;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    offer_ip_d    = offer_ip_q;
    srv_d         = srv_q;
    tx_req_d      = tx_req_q;
    tx_msg_type_d = tx_msg_type_q;
    tx_xid_d      = tx_xid_q;
    tx_req_ipv4_d = tx_req_ipv4_q;
    tx_srv_id_d   = tx_srv_id_q;
    ipv4_addr_d   = ipv4_addr_q;
    lease_d       = lease_q;
    ready_d       = ready_q;
    fail_d        = fail_q;
    xid_adv       = 1'b0;
    do_retry      = 1'b0;

    case (state_q)
      IDLE, BOUND_S, FAIL_S: begin
        if (start) begin
          ready_d     = 1'b0;
          fail_d      = 1'b0;
          retry_d     = 4'd0;
          ipv4_addr_d = '0;
          lease_d     = '0;
          xid_adv     = 1'b1;
          state_d     = DISC_S;
        end
      end
      DISC_S: begin
        tx_msg_type_d = DHCP_MSG_DISCOVER;
        tx_xid_d      = xid;
        tx_req_ipv4_d = '0;
        tx_srv_id_d   = '0;
        if (tx_ack) begin
          tx_req_d = 1'b0;
          timer_d  = '0;
          state_d  = OFFER_WAIT_S;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      OFFER_WAIT_S: begin
        timer_d = timer_q + TW'(1);
        // A matched message takes priority over a timeout in the same cycle.
        if (rx_match && (rx_msg_type == DHCP_MSG_OFFER)) begin
          offer_ip_d = rx_yiaddr;
          srv_d      = rx_srv_id;
          state_d    = REQ_S;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      REQ_S: begin
        tx_msg_type_d = DHCP_MSG_REQUEST;
        tx_xid_d      = xid;
        tx_req_ipv4_d = offer_ip_q;
        tx_srv_id_d   = srv_q;
        if (tx_ack) begin
          tx_req_d = 1'b0;
          timer_d  = '0;
          state_d  = ACK_WAIT_S;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      ACK_WAIT_S: begin
        timer_d = timer_q + TW'(1);
        if (rx_match && (rx_msg_type == DHCP_MSG_ACK) && (rx_srv_id == srv_q)) begin
          ipv4_addr_d = rx_yiaddr;
          lease_d     = rx_lease;
          ready_d     = 1'b1;
          state_d     = BOUND_S;
        end else if (rx_match && (rx_msg_type == DHCP_MSG_NAK)) begin
          do_retry = 1'b1;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_retry) begin
      if (retry_q == RETRY_LAST) begin
        fail_d  = 1'b1;
        state_d = FAIL_S;
      end else begin
        retry_d = retry_q + 4'd1;
        xid_adv = 1'b1;
        state_d = DISC_S;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      retry_q       <= 4'd0;
      offer_ip_q    <= '0;
      srv_q         <= '0;
      tx_req_q      <= 1'b0;
      tx_msg_type_q <= 8'd0;
      tx_xid_q      <= '0;
      tx_req_ipv4_q <= '0;
      tx_srv_id_q   <= '0;
      ipv4_addr_q   <= '0;
      lease_q       <= '0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      offer_ip_q    <= offer_ip_d;
      srv_q         <= srv_d;
      tx_req_q      <= tx_req_d;
      tx_msg_type_q <= tx_msg_type_d;
      tx_xid_q      <= tx_xid_d;
      tx_req_ipv4_q <= tx_req_ipv4_d;
      tx_srv_id_q   <= tx_srv_id_d;
      ipv4_addr_q   <= ipv4_addr_d;
      lease_q       <= lease_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign tx_req      = tx_req_q;
  assign tx_msg_type = tx_msg_type_q;
  assign tx_xid      = tx_xid_q;
  assign tx_req_ipv4 = tx_req_ipv4_q;
  assign tx_srv_id   = tx_srv_id_q;
  assign ipv4_addr   = ipv4_addr_q;
  assign lease       = lease_q;
  assign ready       = ready_q;
  assign fail        = fail_q;

endmodule
